// File: rtl/ad5065_pkg.sv
// Shared AD5065 definitions: command/address codes, frame layout, scheduler FSM states.
package ad5065_pkg;

  localparam int unsigned FRAME_W = 32;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned DATA_W  = 16;

  // Frame field offsets (LSB of each field)
  localparam int unsigned CMD_LSB  = 24;
  localparam int unsigned ADDR_LSB = 20;
  localparam int unsigned DATA_LSB = 4;

  // AD5065 command codes C3..C0
  localparam logic [NIB_W-1:0] CMD_WR_INPUT  = 4'b0000;
  localparam logic [NIB_W-1:0] CMD_UPDATE    = 4'b0001;
  localparam logic [NIB_W-1:0] CMD_WR_UPDATE = 4'b0011;
  localparam logic [NIB_W-1:0] CMD_POWER     = 4'b0100;
  localparam logic [NIB_W-1:0] CMD_RESET     = 4'b0111;

  // AD5065 address codes A3..A0
  localparam logic [NIB_W-1:0] ADDR_A   = 4'b0000;
  localparam logic [NIB_W-1:0] ADDR_B   = 4'b0011;
  localparam logic [NIB_W-1:0] ADDR_ALL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Assemble a 32-bit frame; the top and bottom nibbles are don't-care zeros
  function automatic logic [FRAME_W-1:0] build_frame(input logic [NIB_W-1:0]  code,
                                                     input logic [NIB_W-1:0]  addr,
                                                     input logic [DATA_W-1:0] data);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[CMD_LSB  +: NIB_W]  = code;
    f[ADDR_LSB +: NIB_W]  = addr;
    f[DATA_LSB +: DATA_W] = data;
    return f;
  endfunction

endpackage

// File: rtl/ad5065_spi_shifter.sv
// AD5065 SPI shifter: SCLK divider, bit counter and shift register for one 32-bit frame.
// The cycle after start is a lead cycle (sclk high, din = MSB) that covers the scheduler's LOAD state.
module ad5065_spi_shifter
  import ad5065_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  output logic               done,
  output logic               sclk,
  output logic               din
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = 5;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);

  logic [FRAME_W-1:0] sreg;
  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic               active;
  logic               lead;
  logic               phase_end;

  assign phase_end = (div_cnt == DIV_W'(CLK_DIV - 1));

  // Last cycle of the 32nd low phase
  assign done = active && !lead && !sclk && phase_end && (bit_cnt == LAST_BIT);

  // Half-period divider, phase toggling and MSB-first shifting; din changes only as sclk rises
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg    <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      active  <= 1'b0;
      lead    <= 1'b0;
      sclk    <= 1'b1;
      din     <= 1'b0;
    end else if (start) begin
      sreg    <= frame;
      din     <= frame[FRAME_W-1];
      sclk    <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
      active  <= 1'b1;
      lead    <= 1'b1;
    end else if (lead) begin
      lead <= 1'b0;
    end else if (active) begin
      if (!phase_end) begin
        div_cnt <= div_cnt + DIV_W'(1);
      end else begin
        div_cnt <= '0;
        if (sclk) begin
          sclk <= 1'b0;
        end else if (bit_cnt == LAST_BIT) begin
          sclk   <= 1'b1;
          active <= 1'b0;
        end else begin
          sclk    <= 1'b1;
          bit_cnt <= bit_cnt + BIT_W'(1);
          sreg    <= {sreg[FRAME_W-2:0], 1'b0};
          din     <= sreg[FRAME_W-2];
        end
      end
    end
  end

endmodule

// File: rtl/ad5065_frame_scheduler.sv
// AD5065 frame scheduler: arbitrates command / channel A / channel B requests and sequences
// one SPI frame per grant (IDLE -> LOAD -> SHIFT -> GAP).
// Optional feature macro: AD5065_LDAC_SYNC_EN (channel frames write input registers only and
// an LDAC_n pulse after each channel-B frame updates both DACs together).
module ad5065_frame_scheduler
  import ad5065_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned SYNC_GAP = 2,
  parameter int unsigned LDAC_W   = 2
) (
  input  logic        s00_axi_aclk,
  input  logic        s00_axi_aresetn,
  input  logic        enable,
  input  logic [15:0] cha_data,
  input  logic        cha_valid,
  output logic        cha_ready,
  input  logic [15:0] chb_data,
  input  logic        chb_valid,
  output logic        chb_ready,
  input  logic [3:0]  cmd_code,
  input  logic [3:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        dac_sclk,
  output logic        dac_sync_n,
  output logic        dac_din,
  output logic        dac_ldac_n
);

`ifdef AD5065_LDAC_SYNC_EN
  localparam bit               LDAC_EN = 1'b1;
  localparam logic [NIB_W-1:0] CH_CMD  = CMD_WR_INPUT;
`else
  localparam bit               LDAC_EN = 1'b0;
  localparam logic [NIB_W-1:0] CH_CMD  = CMD_WR_UPDATE;
`endif

  localparam int unsigned LDAC_GAP = LDAC_W + 1;
  localparam int unsigned GAP_LEN  = (LDAC_EN && (LDAC_GAP > SYNC_GAP)) ? LDAC_GAP : SYNC_GAP;
  localparam int unsigned GAP_W    = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  state_t             state, state_d;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_d;
  logic               rr_b;
  logic               sel_cmd, sel_a, sel_b, grant;
  logic [FRAME_W-1:0] frame_d;
  logic               shift_done;
  logic               busy_d, sync_n_d, frame_done_d;

  // Grant one source in IDLE: command first, then round-robin between A and B
  always_comb begin
    sel_cmd = 1'b0;
    sel_a   = 1'b0;
    sel_b   = 1'b0;
    if (s00_axi_aresetn && enable && (state == ST_IDLE)) begin
      if (cmd_valid)                             sel_cmd = 1'b1;
      else if (cha_valid && (!chb_valid || !rr_b)) sel_a = 1'b1;
      else if (chb_valid)                        sel_b   = 1'b1;
    end
  end

  assign grant     = sel_cmd | sel_a | sel_b;
  assign cmd_ready = sel_cmd;
  assign cha_ready = sel_a;
  assign chb_ready = sel_b;

  // Frame payload of the granted source; captured by the shifter on the grant edge
  always_comb begin
    frame_d = build_frame(CH_CMD, ADDR_A, cha_data);
    if (sel_cmd)    frame_d = build_frame(cmd_code, cmd_addr, cmd_data);
    else if (sel_b) frame_d = build_frame(CH_CMD, ADDR_B, chb_data);
  end

  // Round-robin pointer flips to the other channel after every channel grant
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) rr_b <= 1'b0;
    else if (sel_a)       rr_b <= 1'b1;
    else if (sel_b)       rr_b <= 1'b0;
  end

  // FSM state register (GAP countdown is part of the state)
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_d;
      gap_cnt <= gap_cnt_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d   = state;
    gap_cnt_d = gap_cnt;
    unique case (state)
      ST_IDLE:  if (grant) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (shift_done) begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_W'(GAP_LEN - 1);
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) state_d   = ST_IDLE;
        else               gap_cnt_d = gap_cnt - GAP_W'(1);
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, computed from the next state so the registered copies line up with it
  always_comb begin
    busy_d       = (state_d != ST_IDLE);
    sync_n_d     = !((state_d == ST_LOAD) || (state_d == ST_SHIFT));
    frame_done_d = (state_d == ST_GAP) && (gap_cnt_d == '0);
  end

  // Registered status and SYNC outputs
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
      dac_sync_n <= 1'b1;
    end else begin
      busy       <= busy_d;
      frame_done <= frame_done_d;
      dac_sync_n <= sync_n_d;
    end
  end

  ad5065_spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk   (s00_axi_aclk),
    .rst_n (s00_axi_aresetn),
    .start (grant),
    .frame (frame_d),
    .done  (shift_done),
    .sclk  (dac_sclk),
    .din   (dac_din)
  );

`ifdef AD5065_LDAC_SYNC_EN
  logic frame_is_b;
  logic ldac_d;

  // Remember whether the frame in flight came from channel B
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) frame_is_b <= 1'b0;
    else if (grant)       frame_is_b <= sel_b;
  end

  // LDAC_n low for the first LDAC_W GAP cycles after a channel-B frame
  always_comb begin
    ldac_d = !((state_d == ST_GAP) && frame_is_b && (gap_cnt_d >= GAP_W'(GAP_LEN - LDAC_W)));
  end

  // Registered LDAC_n
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) dac_ldac_n <= 1'b0;
    else                  dac_ldac_n <= ldac_d;
  end
`else
  assign dac_ldac_n = 1'b0;
`endif

endmodule

// File: tb/tb_ad5065_frame_scheduler.sv
// Bench for ad5065_frame_scheduler: directed scenarios plus random traffic against a
// frame-timeline reference model (grant order, per-cycle SPI pin values, frame contents).
module tb_ad5065_frame_scheduler;

  localparam int CD = 2;
  localparam int SG = 2;
  localparam int LW = 2;
`ifdef AD5065_LDAC_SYNC_EN
  localparam int         GAPN = (SG > LW + 1) ? SG : LW + 1;
  localparam logic [3:0] CHC  = 4'h0;
`else
  localparam int         GAPN = SG;
  localparam logic [3:0] CHC  = 4'h3;
`endif
  localparam int SHIFT_END = 1 + 64 * CD;      // age of the last SHIFT cycle
  localparam int FLEN      = SHIFT_END + GAPN; // age of the last GAP cycle
  localparam int BIT10_AGE = 2 + 10 * 2 * CD;

  logic        clk, rstn, enable;
  logic [15:0] a_data, b_data, c_data;
  logic        a_valid, b_valid, c_valid;
  logic        a_ready, b_ready, c_ready;
  logic [3:0]  c_code, c_addr;
  logic        busy, frame_done, dac_sclk, dac_sync_n, dac_din, dac_ldac_n;

  ad5065_frame_scheduler #(.CLK_DIV(CD), .SYNC_GAP(SG), .LDAC_W(LW)) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rstn),
    .enable          (enable),
    .cha_data        (a_data),
    .cha_valid       (a_valid),
    .cha_ready       (a_ready),
    .chb_data        (b_data),
    .chb_valid       (b_valid),
    .chb_ready       (b_ready),
    .cmd_code        (c_code),
    .cmd_addr        (c_addr),
    .cmd_data        (c_data),
    .cmd_valid       (c_valid),
    .cmd_ready       (c_ready),
    .busy            (busy),
    .frame_done      (frame_done),
    .dac_sclk        (dac_sclk),
    .dac_sync_n      (dac_sync_n),
    .dac_din         (dac_din),
    .dac_ldac_n      (dac_ldac_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: frame timeline measured in cycles since the grant
  bit          m_in_frame, m_ptr_b, m_post_reset, m_last_b;
  int          m_age;
  logic [31:0] m_frame;
  int          a_cnt, b_cnt, c_cnt;
  bit          hs_a, hs_b, hs_c;
  logic        prev_sclk, prev_sync;
  logic [31:0] obs_word;
  int          obs_edges;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_frame(input logic [3:0] code, input logic [3:0] addr,
                                          input logic [15:0] data);
    return {4'h0, code, addr, data, 4'h0};
  endfunction

  // One clock: check this cycle's outputs at the falling edge, advance the model,
  // then retire handshaken requests just after the rising edge.
  task automatic step();
    bit ea, eb, ec, e_busy, e_done, e_sclk, e_sync, e_din, e_ldac;
    int k;
    logic [4:0] idx;
    @(negedge clk);
    ea = 0; eb = 0; ec = 0;
    if (rstn && enable && !m_in_frame) begin
      if (c_valid)                  ec = 1;
      else if (a_valid && b_valid)  begin if (m_ptr_b) eb = 1; else ea = 1; end
      else if (a_valid)             ea = 1;
      else if (b_valid)             eb = 1;
    end
    e_busy = m_in_frame;
    e_done = m_in_frame && (m_age == FLEN);
    e_sync = !(m_in_frame && (m_age <= SHIFT_END));
    e_sclk = 1;
    e_din  = 0;
    if (m_in_frame && m_age >= 2 && m_age <= SHIFT_END) begin
      k      = m_age - 2;
      e_sclk = ((k / CD) % 2) == 0;
      idx    = 5'(31 - k / (2 * CD));
      e_din  = m_frame[idx];
    end else if (m_in_frame && m_age == 1) begin
      e_din = m_frame[31];
    end
`ifdef AD5065_LDAC_SYNC_EN
    e_ldac = !(m_post_reset ||
               (m_in_frame && m_last_b && m_age > SHIFT_END && m_age <= SHIFT_END + LW));
`else
    e_ldac = 0;
`endif
    if (prev_sync && !dac_sync_n) begin obs_word = '0; obs_edges = 0; end
    if (prev_sclk && !dac_sclk && !dac_sync_n) begin
      obs_word  = {obs_word[30:0], dac_din};
      obs_edges = obs_edges + 1;
    end
    prev_sclk = dac_sclk;
    prev_sync = dac_sync_n;

    check_eq("cmd_ready",  32'(c_ready),    32'(ec));
    check_eq("cha_ready",  32'(a_ready),    32'(ea));
    check_eq("chb_ready",  32'(b_ready),    32'(eb));
    check_eq("busy",       32'(busy),       32'(e_busy));
    check_eq("frame_done", 32'(frame_done), 32'(e_done));
    check_eq("sync_n",     32'(dac_sync_n), 32'(e_sync));
    check_eq("sclk",       32'(dac_sclk),   32'(e_sclk));
    check_eq("din",        32'(dac_din),    32'(e_din));
    check_eq("ldac_n",     32'(dac_ldac_n), 32'(e_ldac));
    if (e_done) begin
      check_eq("frame_word",    obs_word,        m_frame);
      check_eq("falling_edges", 32'(obs_edges),  32'd32);
    end

    if (!rstn) begin
      m_in_frame   = 0;
      m_ptr_b      = 0;
      m_post_reset = 1;
    end else begin
      m_post_reset = 0;
      if (m_in_frame) begin
        if (m_age == FLEN) m_in_frame = 0;
        else               m_age = m_age + 1;
      end
      if (ec | ea | eb) begin
        m_in_frame = 1;
        m_age      = 1;
        m_last_b   = eb;
        if (ec)      m_frame = mk_frame(c_code, c_addr, c_data);
        else if (ea) m_frame = mk_frame(CHC, 4'h0, a_data);
        else         m_frame = mk_frame(CHC, 4'h3, b_data);
        if (ea) m_ptr_b = 1;
        if (eb) m_ptr_b = 0;
      end
    end
    hs_a = ea; hs_b = eb; hs_c = ec;

    @(posedge clk);
    #1;
    if (hs_a) begin a_cnt--; if (a_cnt <= 0) a_valid = 0; end
    if (hs_b) begin b_cnt--; if (b_cnt <= 0) b_valid = 0; end
    if (hs_c) begin c_cnt--; if (c_cnt <= 0) c_valid = 0; end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic req_a(input logic [15:0] d, input int n);
    a_data = d; a_cnt = n; a_valid = 1;
  endtask

  task automatic req_b(input logic [15:0] d, input int n);
    b_data = d; b_cnt = n; b_valid = 1;
  endtask

  task automatic req_c(input logic [3:0] code, input logic [3:0] addr, input logic [15:0] d);
    c_code = code; c_addr = addr; c_data = d; c_cnt = 1; c_valid = 1;
  endtask

  // Advance until the model reaches the given frame age (bounded)
  task automatic run_to_age(input int age);
    for (int i = 0; i < 4 * FLEN; i++) begin
      if (m_in_frame && m_age == age) break;
      step();
    end
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      if (!a_valid && $urandom_range(0, 7) == 0)  req_a(16'($urandom()), 1);
      if (!b_valid && $urandom_range(0, 7) == 0)  req_b(16'($urandom()), 1);
      if (!c_valid && $urandom_range(0, 15) == 0)
        req_c(4'($urandom()), 4'($urandom()), 16'($urandom()));
      if (enable && $urandom_range(0, 149) == 0)      enable = 0;
      else if (!enable && $urandom_range(0, 19) == 0) enable = 1;
      rstn = ($urandom_range(0, 999) != 0);
      step();
    end
    rstn   = 1;
    enable = 1;
  endtask

  initial begin
    rstn = 0; enable = 1;
    a_valid = 0; b_valid = 0; c_valid = 0;
    a_data = '0; b_data = '0; c_data = '0; c_code = '0; c_addr = '0;
    a_cnt = 0; b_cnt = 0; c_cnt = 0;
    m_in_frame = 0; m_ptr_b = 0; m_post_reset = 1; m_last_b = 0; m_age = 0; m_frame = '0;
    prev_sclk = 1; prev_sync = 1; obs_word = '0; obs_edges = 0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1;

    // Quiet period after reset
    run(10);

    // Single channel-A sample
    req_a(16'hABCD, 1);
    run(FLEN + 5);

    // Reset between frames returns the pointer to A, then A/B held together alternate
    rstn = 0; step(); rstn = 1;
    req_a(16'hABCD, 2);
    req_b(16'h1234, 2);
    run(4 * (FLEN + 1) + 5);

    // Command beats both channels
    req_c(4'h7, 4'hF, 16'h0000);
    req_a(16'h1111, 1);
    req_b(16'h2222, 1);
    run(3 * (FLEN + 1) + 5);

    // Reset at bit 10 aborts the frame; the next request completes normally
    req_a(16'h5A5A, 1);
    run_to_age(BIT10_AGE);
    check_eq("bit10_busy",   32'(busy),       32'd1);
    check_eq("bit10_sync_n", 32'(dac_sync_n), 32'd0);
    rstn = 0; step(); rstn = 1;
    check_eq("abort_sync_n", 32'(dac_sync_n), 32'd1);
    check_eq("abort_sclk",   32'(dac_sclk),   32'd1);
    check_eq("abort_busy",   32'(busy),       32'd0);
    req_b(16'h0F0F, 1);
    run(FLEN + 5);

    // Enable dropped mid-frame: frame completes, no further grant while disabled
    req_a(16'hC3C3, 2);
    run_to_age(50);
    enable = 0;
    run(2 * FLEN);
    check_eq("held_valid", 32'(a_valid), 32'd1);
    enable = 1;
    run(FLEN + 5);

    // Random traffic with enable toggles and occasional resets
    random_run(3000);
    run(FLEN + 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
